multi_edge_det: RTL and testbench
=================================

# multi_edge_det

Multi-channel, parametrised edge detector: it synchronises CHANNELS asynchronous inputs, optionally debounces them, and detects edges on each channel under a per-channel mode. For every channel it produces a one-cycle edge pulse and a sticky flag that software clears with write-1-to-clear. It sits between raw board or pad inputs and the control FSMs and register blocks that consume edge events.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: flip-flops per synchroniser chain (≥2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synchronised value must hold before it is accepted (≥1).
- RST_VAL, 1'b0: reset value of every synchroniser stage and of each channel's stable value.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- async_in  in  CHANNELS  raw asynchronous inputs.
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]:
  - 00: off.
  - 01: rise.
  - 10: fall.
  - 11: both.
- clear  in  CHANNELS  write-1-to-clear strobes for edge_sticky.
- sync_out  out  CHANNELS  last synchroniser stage.
- stable_out  out  CHANNELS  debounced level.
- edge_pulse  out  CHANNELS  one-cycle registered edge event.
- edge_sticky  out  CHANNELS  latched edge event.

## Operation
- **Synchroniser.** Each channel has a SYNC_STAGES-deep flip-flop chain; sync_out is the final stage.
- **Debounce, per channel.**
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync_out equals stable, cnt is set to 0.
  - If sync_out differs from stable and cnt == DEBOUNCE_CYCLES-1: stable takes sync_out and cnt is set to 0 (this is the "update").
  - If sync_out differs from stable otherwise, cnt increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- **Edge qualification.** On an update:
  - A 0→1 update is a rise and qualifies if mode[2i] is set.
  - A 1→0 update is a fall and qualifies if mode[2i+1] is set.
  - Mode is sampled on the update edge, so a mode change only affects later updates.
- **edge_pulse[i].** Registered. High for exactly the cycle in which the new stable value is first visible, and only if that update qualifies.
- **edge_sticky[i].**
  - Set to 1 on the edge that raises edge_pulse[i].
  - Cleared when clear[i] is 1.
  - If set and clear occur on the same edge, set wins and the flag stays 1.
- **Channel independence.** Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.
- **Reset values.** While rst is high at a clock edge:
  - All synchroniser stages and stable take RST_VAL.
  - cnt takes 0.
  - edge_pulse and edge_sticky take 0.
- **Reset mid-operation.** A reset during debounce discards the count. A level that differs from RST_VAL after reset is seen as a new edge and debounced normally.

## Timing
- Take async_in[i] as changed before sampling edge 1.
- sync_out changes after edge SYNC_STAGES.
- stable_out and edge_pulse change after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- edge_pulse drops after the following edge.
- edge_sticky rises together with edge_pulse.
- clear[i] takes effect at the next edge.
- rst is effective only at a clock edge. All outputs are registered.

## Configuration
- Macro: MULTI_EDGE_DET_DEBOUNCE_EN.
- Defined: the debounce counter described above is built.
- Undefined:
  - The counter is removed and stable takes sync_out on every edge, so every update behaves as DEBOUNCE_CYCLES=1.
  - The parameter is ignored.
  - The edge therefore appears after edge SYNC_STAGES+1.

## Structure
- Package multi_edge_det_pkg holds:
  - typedef edge_mode_t as logic [1:0].
  - Constants MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH.
- Sub-module sync_chain: a single-bit synchroniser parameterised by SYNC_STAGES and RST_VAL, instantiated once per channel in a generate loop.
- Debounce, qualification and sticky logic live in the top module, one generate iteration per channel.

## Test plan
Defaults apply (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_VAL=0) unless a scenario says otherwise.
- **Rise detection.** Channel 0 in MODE_RISE; async_in[0] goes 0→1 before edge 1.
  - sync_out[0] is 1 after edge 2.
  - stable_out[0], edge_pulse[0] and edge_sticky[0] are 1 after edge 6.
  - edge_pulse[0] is 0 after edge 7 and edge_sticky[0] stays 1.
- **Glitch rejection.** async_in[1] is high for 3 cycles, then low.
  - stable_out[1], edge_pulse[1] and edge_sticky[1] stay 0 throughout.
- **Mode filtering.** Channel 2 in MODE_FALL; apply a rise, then a fall, each held for 10 cycles.
  - Only the fall pulses.
  - In MODE_BOTH both pulse; in MODE_OFF neither pulses and stable_out still follows the input.
- **Clear versus set.** Assert clear[3] on the same edge that a qualifying edge_pulse[3] is set.
  - edge_sticky[3] stays 1.
  - A lone clear[3] on a later edge drives it to 0.
- **Reset mid-operation.** Pulse rst on the edge where cnt=2 while async_in[0]=1.
  - All outputs are 0 after that edge.
  - The edge is re-detected 6 edges after rst deasserts.
- **Macro undefined.** Repeat the rise detection scenario.
  - edge_pulse[0] is high after edge 3 only.

Source files
------------

// File: rtl/multi_edge_det_pkg.sv
// Shared types, mode encodings and the edge qualification helper for multi_edge_det.
package multi_edge_det_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t MODE_OFF  = 2'b00;
  localparam edge_mode_t MODE_RISE = 2'b01;
  localparam edge_mode_t MODE_FALL = 2'b10;
  localparam edge_mode_t MODE_BOTH = 2'b11;

  // Bit 0 of the mode enables rising updates, bit 1 enables falling updates.
  function automatic logic edge_qualifies(edge_mode_t mode, logic prev, logic next);
    return (!prev && next && mode[0]) || (prev && !next && mode[1]);
  endfunction

endpackage

// File: rtl/multi_edge_det_sync_chain.sv
// Single-bit synchroniser: SYNC_STAGES flip-flops in series, reset to RST_VAL.
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: state registers use non-blocking assignment so every stage samples the
  // value its predecessor held before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/multi_edge_det.sv
// Multi-channel edge detector: synchronise, debounce, qualify by mode, pulse and sticky flag.
// Debounce counter is built only when MULTI_EDGE_DET_DEBOUNCE_EN is defined.
module multi_edge_det
  import multi_edge_det_pkg::*;
#(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   async_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   sync_out,
  output logic [CHANNELS-1:0]   stable_out,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   edge_sticky
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("multi_edge_det: CHANNELS>=1, SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1 required");
  end

`ifdef MULTI_EDGE_DET_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic       stable_q;
    logic       pulse_q;
    logic       sticky_q;
    logic       update;
    logic       hit;
    edge_mode_t ch_mode;

    sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (async_in[i]),
      .q   (sync_out[i])
    );

    assign ch_mode = mode[2*i +: 2];

`ifdef MULTI_EDGE_DET_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;

    // The count restarts whenever the input agrees with stable or an update lands.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (sync_out[i] == stable_q || update) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign update = (sync_out[i] != stable_q) && (cnt == CNT_LAST);
`else
    assign update = (sync_out[i] != stable_q);
`endif

    // Mode is sampled here, on the update edge only.
    assign hit = update && edge_qualifies(ch_mode, stable_q, sync_out[i]);

    always_ff @(posedge clk) begin
      if (rst) begin
        stable_q <= RST_VAL;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        pulse_q <= hit;
        if (update) begin
          stable_q <= sync_out[i];
        end
        // A set on the same edge as a clear takes priority.
        if (hit) begin
          sticky_q <= 1'b1;
        end else if (clear[i]) begin
          sticky_q <= 1'b0;
        end
      end
    end

    assign stable_out[i]  = stable_q;
    assign edge_pulse[i]  = pulse_q;
    assign edge_sticky[i] = sticky_q;
  end

endmodule

// File: tb/tb_multi_edge_det.sv
// Scoreboard bench for multi_edge_det: stimulus queues expectations, a monitor checks them.
module tb_multi_edge_det;
  import multi_edge_det_pkg::*;

`ifdef MULTI_EDGE_DET_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  localparam int LAT = 2 + DB;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in, clear, sync_out, stable_out, edge_pulse, edge_sticky;
  logic [7:0] mode;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  typedef enum {SIG_SYNC, SIG_STABLE, SIG_STICKY} sig_e;
  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [3:0] mask;
    logic [3:0] val;
    string      name;
  } lvl_t;
  typedef struct {
    int         cyc;
    logic [3:0] val;
    string      name;
  } pls_t;

  lvl_t lq[$];
  pls_t pq[$];

  multi_edge_det #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RST_VAL         (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .async_in    (async_in),
    .mode        (mode),
    .clear       (clear),
    .sync_out    (sync_out),
    .stable_out  (stable_out),
    .edge_pulse  (edge_pulse),
    .edge_sticky (edge_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_lvl(int c, sig_e s, logic [3:0] m, logic [3:0] v, string n);
    lvl_t e;
    e.cyc = c; e.sig = s; e.mask = m; e.val = v; e.name = n;
    lq.push_back(e);
  endtask

  task automatic expect_pulse(int c, logic [3:0] v, string n);
    pls_t e;
    e.cyc = c; e.val = v; e.name = n;
    pq.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(int ch, edge_mode_t m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic clear_all(string n);
    int c;
    c = cyc;
    clear = 4'hF;
    expect_lvl(c + 1, SIG_STICKY, 4'hF, 4'h0, n);
    step(1);
    clear = 4'h0;
    step(1);
  endtask

  // Monitor: every pulse event is matched against the pulse queue; level
  // expectations are compared on the cycle they name.
  initial begin
    pls_t       p;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        check(p.name, {28'b0, edge_pulse}, {28'b0, p.val});
      end else if (edge_pulse !== 4'h0) begin
        check("pulse_unexpected", {28'b0, edge_pulse}, 32'h0);
      end
      for (int k = lq.size() - 1; k >= 0; k--) begin
        if (lq[k].cyc <= cyc) begin
          case (lq[k].sig)
            SIG_SYNC:   act = sync_out;
            SIG_STABLE: act = stable_out;
            default:    act = edge_sticky;
          endcase
          check(lq[k].name, {28'b0, act & lq[k].mask}, {28'b0, lq[k].val});
          lq.delete(k);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b, c;
    edge_mode_t modes [3] = '{MODE_FALL, MODE_BOTH, MODE_OFF};
    logic       exp_rise [3] = '{1'b0, 1'b1, 1'b0};
    logic       exp_fall [3] = '{1'b1, 1'b1, 1'b0};

    rst = 1'b1; async_in = '0; mode = '0; clear = '0;

    // Reset state
    step(1);
    expect_lvl(2, SIG_SYNC,   4'hF, 4'h0, "reset_sync");
    expect_lvl(2, SIG_STABLE, 4'hF, 4'h0, "reset_stable");
    expect_lvl(2, SIG_STICKY, 4'hF, 4'h0, "reset_sticky");
    step(1);
    rst = 1'b0;
    step(1);

    // Rise detection on channel 0
    set_mode(0, MODE_RISE);
    b = cyc;
    async_in[0] = 1'b1;
    expect_lvl(b + 1, SIG_SYNC, 4'h1, 4'h0, "rise_sync_early");
    expect_lvl(b + 2, SIG_SYNC, 4'h1, 4'h1, "rise_sync");
    expect_lvl(b + LAT - 1, SIG_STABLE, 4'h1, 4'h0, "rise_stable_early");
    expect_lvl(b + LAT, SIG_STABLE, 4'h1, 4'h1, "rise_stable");
    expect_pulse(b + LAT, 4'h1, "rise_pulse");
    expect_lvl(b + LAT, SIG_STICKY, 4'h1, 4'h1, "rise_sticky");
    expect_lvl(b + LAT + 1, SIG_STICKY, 4'h1, 4'h1, "rise_sticky_hold");
    step(LAT + 3);
    c = cyc;
    clear[0] = 1'b1;
    expect_lvl(c + 1, SIG_STICKY, 4'h1, 4'h0, "rise_sticky_clear");
    step(1);
    clear = '0;
    step(2);

    // Glitch of 3 cycles on channel 1
    set_mode(1, MODE_BOTH);
    b = cyc;
    async_in[1] = 1'b1;
    if (3 < DB) begin
      for (int k = 2; k <= 10; k += 2)
        expect_lvl(b + k, SIG_STABLE, 4'h2, 4'h0, "glitch_stable");
      expect_lvl(b + 10, SIG_STICKY, 4'h2, 4'h0, "glitch_sticky");
    end else begin
      expect_lvl(b + 3, SIG_STABLE, 4'h2, 4'h2, "glitch_nodb_stable_hi");
      expect_pulse(b + 3, 4'h2, "glitch_nodb_rise");
      expect_pulse(b + 6, 4'h2, "glitch_nodb_fall");
      expect_lvl(b + 6, SIG_STABLE, 4'h2, 4'h0, "glitch_nodb_stable_lo");
      expect_lvl(b + 10, SIG_STICKY, 4'h2, 4'h2, "glitch_nodb_sticky");
    end
    step(3);
    async_in[1] = 1'b0;
    step(8);
    clear_all("glitch_clear_all");

    // Mode filtering on channel 2
    for (int k = 0; k < 3; k++) begin
      set_mode(2, modes[k]);
      b = cyc;
      async_in[2] = 1'b1;
      expect_lvl(b + LAT, SIG_STABLE, 4'h4, 4'h4, "mode_stable_rise");
      if (exp_rise[k]) expect_pulse(b + LAT, 4'h4, "mode_rise_pulse");
      step(10);
      b = cyc;
      async_in[2] = 1'b0;
      expect_lvl(b + LAT, SIG_STABLE, 4'h4, 4'h0, "mode_stable_fall");
      if (exp_fall[k]) expect_pulse(b + LAT, 4'h4, "mode_fall_pulse");
      step(10);
    end
    clear_all("mode_clear_all");

    // Clear on the same edge as a qualifying set, channel 3
    set_mode(3, MODE_RISE);
    b = cyc;
    async_in[3] = 1'b1;
    expect_lvl(b + LAT - 1, SIG_STICKY, 4'h8, 4'h0, "clrset_sticky_before");
    expect_pulse(b + LAT, 4'h8, "clrset_pulse");
    expect_lvl(b + LAT, SIG_STICKY, 4'h8, 4'h8, "clrset_sticky_set_wins");
    expect_lvl(b + LAT + 1, SIG_STICKY, 4'h8, 4'h8, "clrset_sticky_hold");
    step(LAT - 1);
    clear[3] = 1'b1;
    step(1);
    clear = '0;
    step(2);
    c = cyc;
    clear[3] = 1'b1;
    expect_lvl(c + 1, SIG_STICKY, 4'h8, 4'h0, "clrset_lone_clear");
    step(1);
    clear = '0;
    step(1);

    // Simultaneous edges across channels
    mode = 8'hFF;
    b = cyc;
    async_in = 4'hF;
    expect_pulse(b + LAT, 4'h6, "multi_rise_pulse");
    expect_lvl(b + LAT, SIG_STICKY, 4'hF, 4'h6, "multi_rise_sticky");
    step(LAT + 2);
    b = cyc;
    async_in = 4'h0;
    expect_lvl(b + LAT - 1, SIG_STABLE, 4'hF, 4'hF, "multi_fall_stable_before");
    expect_lvl(b + LAT, SIG_STABLE, 4'hF, 4'h0, "multi_fall_stable");
    expect_pulse(b + LAT, 4'hF, "multi_fall_pulse");
    step(LAT + 2);
    clear_all("multi_clear_all");

    // Reset in the middle of a debounce
    mode = '0;
    set_mode(0, MODE_RISE);
    b = cyc;
    async_in[0] = 1'b1;
    if (LAT <= 4) expect_pulse(b + LAT, 4'h1, "rstmid_nodb_pulse");
    step(4);
    rst = 1'b1;
    expect_lvl(b + 5, SIG_SYNC,   4'hF, 4'h0, "rstmid_sync");
    expect_lvl(b + 5, SIG_STABLE, 4'hF, 4'h0, "rstmid_stable");
    expect_lvl(b + 5, SIG_STICKY, 4'hF, 4'h0, "rstmid_sticky");
    step(1);
    rst = 1'b0;
    c = cyc;
    expect_lvl(c + LAT - 1, SIG_STABLE, 4'h1, 4'h0, "rstmid_stable_early");
    expect_lvl(c + LAT, SIG_STABLE, 4'h1, 4'h1, "rstmid_stable_redetect");
    expect_pulse(c + LAT, 4'h1, "rstmid_pulse_redetect");
    expect_lvl(c + LAT, SIG_STICKY, 4'h1, 4'h1, "rstmid_sticky_redetect");
    step(LAT + 3);

    for (int i = 0; i < 50 && (pq.size() > 0 || lq.size() > 0); i++) step(1);
    check("pulse_queue_drained", pq.size(), 0);
    check("level_queue_drained", lq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
